// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB walk with a MEM wait timeout.
// Optional performance counters are enabled by defining MC_PERF_COUNTERS_EN.
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_in,
  input  logic        mem_ready,
  output logic [31:0] ir,
  output logic [4:0]  opcode,
  output logic        ir_we,
  output logic        pc_we,
  output logic        jump,
  output logic        rf_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        alu_src_b,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic [2:0]  state
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  state_t      state_q, state_d;
  logic [31:0] wait_cnt;
  logic        is_load, is_store, is_branch, is_jump, legal, imm_b, mem_timeout;
  logic        ir_we_d, pc_we_d, jump_d, rf_we_d, mem_re_d, mem_we_d, alu_b_d;
  logic [1:0]  wb_sel_d;

  assign opcode    = ir[6:2];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign legal     = (ir[1:0] == 2'b11) &&
                     (is_load || is_store || is_branch || is_jump ||
                      opcode == OP_OP || opcode == OP_OPIMM ||
                      opcode == OP_LUI || opcode == OP_AUIPC);
  assign imm_b     = is_load || is_store || opcode == OP_OPIMM ||
                     opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JALR;

  // A ready arriving in the cycle that would have timed out still completes the access.
  assign mem_timeout = (MEM_TIMEOUT != 0) && !mem_ready &&
                       ((wait_cnt + 32'd1) == MEM_TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      ir       <= 32'h0000_0013;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (ir_we_d) ir <= instr_in;
      if (state_q != S_MEM) wait_cnt <= '0;
      else if (!mem_ready)  wait_cnt <= wait_cnt + 32'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_we_d  = 1'b0;
    pc_we_d  = 1'b0;
    jump_d   = 1'b0;
    rf_we_d  = 1'b0;
    mem_re_d = 1'b0;
    mem_we_d = 1'b0;
    alu_b_d  = 1'b0;
    wb_sel_d = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_we_d = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alu_b_d = imm_b;
        if (is_branch) begin
          pc_we_d = 1'b1;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_b_d  = imm_b;
        mem_re_d = is_load;
        mem_we_d = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_we_d = 1'b1;
            state_d = S_FETCH;
          end
        end else if (mem_timeout) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        alu_b_d  = imm_b;
        rf_we_d  = 1'b1;
        pc_we_d  = 1'b1;
        jump_d   = is_jump;
        wb_sel_d = is_jump ? 2'b10 : (is_load ? 2'b01 : 2'b00);
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Strobes are held low for as long as reset is asserted, not just at the edge.
  assign ir_we     = reset & ir_we_d;
  assign pc_we     = reset & pc_we_d;
  assign jump      = reset & jump_d;
  assign rf_we     = reset & rf_we_d;
  assign mem_re    = reset & mem_re_d;
  assign mem_we    = reset & mem_we_d;
  assign alu_src_b = reset & alu_b_d;
  assign wb_sel    = reset ? wb_sel_d : 2'b00;
  assign halted    = (state_q == S_TRAP);
  assign state     = state_q;

`ifdef MC_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state_q != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we_d)           instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: a per-instruction cycle schedule built from the
// instruction class and memory wait is compared against the DUT every cycle.
module tb_mc_control_fsm;
  localparam int unsigned T = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        mem_ready;
  logic [31:0] ir;
  logic [4:0]  opcode;
  logic        ir_we, pc_we, jump, rf_we, mem_re, mem_we, alu_src_b, halted;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .mem_ready(mem_ready),
    .ir(ir), .opcode(opcode), .ir_we(ir_we), .pc_we(pc_we), .jump(jump),
    .rf_we(rf_we), .mem_re(mem_re), .mem_we(mem_we), .alu_src_b(alu_src_b),
    .wb_sel(wb_sel), .halted(halted), .state(state)
`ifdef MC_PERF_COUNTERS_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       ir_we, pc_we, jump, rf_we, mem_re, mem_we, alu_b;
    logic [1:0] wb;
    logic       halted;
  } obs_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ir;
  obs_t        exp_q[$];
  bit          rdy_q[$];
  logic [4:0]  legal_ops [9] = '{5'b00000, 5'b01000, 5'b01100, 5'b00100, 5'b11000,
                                 5'b11011, 5'b11001, 5'b01101, 5'b00101};

  function automatic obs_t obs_now();
    return {state, ir_we, pc_we, jump, rf_we, mem_re, mem_we, alu_src_b, wb_sel, halted};
  endfunction

  function automatic obs_t mk(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic void push(input obs_t o, input bit r);
    exp_q.push_back(o);
    rdy_q.push_back(r);
  endfunction

  function automatic void push_trap();
    obs_t o;
    o = mk(3'd7);
    o.halted = 1'b1;
    for (int k = 0; k < 3; k++) push(o, bit'($urandom_range(0, 1)));
  endfunction

  // Expected cycle-by-cycle schedule of one instruction; w = mem_ready-low cycles in MEM.
  function automatic void build_trace(input logic [31:0] instr, input int w);
    logic [4:0] opc;
    bit ld, sr, br, jl, legal, immb;
    obs_t o;
    opc   = instr[6:2];
    ld    = (opc == 5'b00000);
    sr    = (opc == 5'b01000);
    br    = (opc == 5'b11000);
    jl    = (opc == 5'b11011) || (opc == 5'b11001);
    legal = (instr[1:0] == 2'b11) && (opc inside {5'b00000, 5'b01000, 5'b01100, 5'b00100,
             5'b11000, 5'b11011, 5'b11001, 5'b01101, 5'b00101});
    immb  = opc inside {5'b00100, 5'b00000, 5'b01000, 5'b01101, 5'b00101, 5'b11001};
    exp_q.delete();
    rdy_q.delete();
    o = mk(3'd0);
    o.ir_we = 1'b1;
    push(o, bit'($urandom_range(0, 1)));
    push(mk(3'd1), bit'($urandom_range(0, 1)));
    if (!legal) begin
      push_trap();
      return;
    end
    o = mk(3'd2);
    o.alu_b = immb;
    o.pc_we = br;
    push(o, bit'($urandom_range(0, 1)));
    if (br) return;
    if (ld || sr) begin
      for (int i = 0; i < 1000; i++) begin
        o = mk(3'd3);
        o.alu_b  = immb;
        o.mem_re = ld;
        o.mem_we = sr;
        if (i >= w) begin
          o.pc_we = sr;
          push(o, 1'b1);
          break;
        end
        push(o, 1'b0);
        if (i + 1 == T) begin
          push_trap();
          return;
        end
      end
      if (sr) return;
    end
    o = mk(3'd4);
    o.alu_b = immb;
    o.rf_we = 1'b1;
    o.pc_we = 1'b1;
    o.jump  = jl;
    o.wb    = jl ? 2'b10 : (ld ? 2'b01 : 2'b00);
    push(o, bit'($urandom_range(0, 1)));
  endfunction

  task automatic apply_reset(input string name);
    obs_t a;
    reset = 1'b0;
    #1;
    a = obs_now();
    checks++;
    if (a !== obs_t'('0) || ir !== 32'h0000_0013 || opcode !== 5'b00100) begin
      errors++;
      $display("FAIL %s reset: got obs=%h ir=%h opcode=%b, expected obs=%h ir=00000013 opcode=00100",
               name, a, ir, opcode, obs_t'('0));
    end
    @(posedge clk);
    #1;
    reset  = 1'b1;
    exp_ir = 32'h0000_0013;
  endtask

  // Starts at posedge+1 of a FETCH cycle; abort_at >= 0 pulses reset in that cycle.
  task automatic run_trace(input string name, input logic [31:0] instr, input int abort_at);
    obs_t a;
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = rdy_q[i];
      instr_in  = (i == 0) ? instr : $urandom;
      @(negedge clk);
      if (i >= 1) exp_ir = instr;
      a = obs_now();
      checks++;
      if (a !== exp_q[i] || ir !== exp_ir || opcode !== exp_ir[6:2]) begin
        errors++;
        $display("FAIL %s cycle %0d: got obs=%h ir=%h, expected obs=%h ir=%h",
                 name, i, a, ir, exp_q[i], exp_ir);
      end
      if (i == abort_at) begin
        #2;
        apply_reset({name, "_abort"});
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_one(input string name, input logic [31:0] instr, input int w);
    build_trace(instr, w);
    run_trace(name, instr, -1);
    if (exp_q[exp_q.size() - 1].st == 3'd7) apply_reset({name, "_rst"});
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    mem_ready = 1'b1;
    instr_in  = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    apply_reset("reset");
  endtask

  task automatic test_alu();
    run_one("addi", 32'h0050_0093, 0);
    run_one("add", 32'h0020_81B3, 0);
    run_one("lui", 32'h1234_50B7, 0);
  endtask

  task automatic test_load_wait();
    run_one("load_w3", 32'h0000_A103, 3);
    run_one("load_w0", 32'h0000_A103, 0);
  endtask

  task automatic test_jal_branch();
    run_one("jal", 32'h0080_00EF, 0);
    run_one("jalr", 32'h0000_80E7, 0);
    run_one("branch", 32'h0020_8463, 0);
  endtask

  task automatic test_illegal();
    run_one("illegal_zero", 32'h0000_0000, 0);
    run_one("illegal_low", 32'h0050_0092, 0);
  endtask

  task automatic test_timeout();
    run_one("store_stuck", 32'h0000_A023, 1000);
    run_one("store_edge", 32'h0000_A023, T - 1);
    run_one("load_timeout", 32'h0000_A103, T);
  endtask

  task automatic test_reset_in_mem();
    build_trace(32'h0000_A103, 10);
    run_trace("load_abort", 32'h0000_A103, 5);
    build_trace(32'h0000_A023, 10);
    run_trace("store_abort", 32'h0000_A023, 4);
    run_one("after_abort", 32'h0050_0093, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] instr;
    int w;
    for (int n = 0; n < 60; n++) begin
      instr = $urandom;
      if ($urandom_range(0, 9) != 0) begin
        instr[6:2] = legal_ops[$urandom_range(0, 8)];
        instr[1:0] = 2'b11;
      end
      case ($urandom_range(0, 9))
        0:       w = T;
        1:       w = T - 1;
        default: w = $urandom_range(0, 3);
      endcase
      run_one("random", instr, w);
    end
  endtask

`ifdef MC_PERF_COUNTERS_EN
  task automatic test_perf();
    apply_reset("perf");
    for (int n = 0; n < 10; n++) begin
      build_trace(32'h0050_0093, 0);
      run_trace("perf_addi", 32'h0050_0093, -1);
    end
    @(negedge clk);
    checks++;
    if (cycle_cnt !== 32'd40 || instret_cnt !== 32'd10) begin
      errors++;
      $display("FAIL perf_counters: got cycle=%0d instret=%0d, expected cycle=40 instret=10",
               cycle_cnt, instret_cnt);
    end
  endtask
`endif

  initial begin
    exp_ir = 32'h0000_0013;
    test_reset();
    test_alu();
    test_load_wait();
    test_jal_branch();
    test_illegal();
    test_timeout();
    test_reset_in_mem();
    test_back_to_back();
`ifdef MC_PERF_COUNTERS_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
